// File: rtl/transformer_pkg.sv
// Shared types for the transformer datapath: lane element type, output-register
// states and the per-lane signed saturating adder.
package transformer_pkg;

  localparam int ELEM_W_DEFAULT = 8;

  typedef logic signed [ELEM_W_DEFAULT-1:0] elem_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Returns {clamped, sum}; overflow shows up as the two top bits of the
  // sign-extended sum disagreeing.
  function automatic logic [ELEM_W_DEFAULT:0] sat_add(input elem_t a, input elem_t b);
    logic [ELEM_W_DEFAULT:0] s;
    s = {a[ELEM_W_DEFAULT-1], a} + {b[ELEM_W_DEFAULT-1], b};
    if (!s[ELEM_W_DEFAULT] && s[ELEM_W_DEFAULT-1])
      return {1'b1, 1'b0, {(ELEM_W_DEFAULT-1){1'b1}}};
    if (s[ELEM_W_DEFAULT] && !s[ELEM_W_DEFAULT-1])
      return {1'b1, 1'b1, {(ELEM_W_DEFAULT-1){1'b0}}};
    return {1'b0, s[ELEM_W_DEFAULT-1:0]};
  endfunction

endpackage

// File: rtl/residual_fifo.sv
// Skip-operand FIFO: power-of-two depth, wrapping pointers, synchronous flush.
// A push is refused while full even when a pop happens in the same cycle.
module residual_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pushOk;
  logic              popOk;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pushOk     = push_i && !full_o;
  assign popOk      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
      if (popOk)  rdPtr_d = rdPtr_q + AW'(1);
      if (pushOk && !popOk)      count_d = count_q + CW'(1);
      else if (popOk && !pushOk) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (pushOk && !flush_i) mem_q[wrPtr_q] <= push_data_i;
  end

endmodule

// File: rtl/mlp_residual_add.sv
// Residual add after the MLP stage: queued skip operands plus MLP results,
// per-lane saturating sum, registered valid/ready output. MLP_RES_SATCNT_EN adds sat_count.
module mlp_residual_add
  import transformer_pkg::*;
#(
  parameter  int ELEM_W = ELEM_W_DEFAULT,
  parameter  int LANES  = 4,
  parameter  int DEPTH  = 16,
  localparam int DATA_W = LANES * ELEM_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  output logic              ready,
  input  logic              skip_valid,
  output logic              skip_ready,
  input  logic [DATA_W-1:0] skip_data,
  input  logic              mlp_valid,
  output logic              mlp_ready,
  input  logic [DATA_W-1:0] mlp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef MLP_RES_SATCNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [DATA_W-1:0] headData;
  logic [DATA_W-1:0] sumData;
  logic [LANES-1:0]  clampMask;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pushEn;
  logic              fire;

  assign skip_ready = !fifoFull;
  assign mlp_ready  = !fifoEmpty && (!out_valid || out_ready) && !init;
  assign pushEn     = skip_valid && skip_ready && !init;
  assign fire       = mlp_valid && mlp_ready;
  assign ready      = fifoEmpty && !out_valid;

  residual_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .flush_i     (init),
    .push_i      (pushEn),
    .push_data_i (skip_data),
    .pop_i       (fire),
    .pop_data_o  (headData),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ELEM_W:0] laneRes;
    assign laneRes = sat_add(headData[g*ELEM_W +: ELEM_W], mlp_data[g*ELEM_W +: ELEM_W]);
    assign sumData[g*ELEM_W +: ELEM_W] = laneRes[ELEM_W-1:0];
    assign clampMask[g] = laneRes[ELEM_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OUT_EMPTY;
      outData_q <= '0;
    end else begin
      state_q   <= state_d;
      outData_q <= outData_d;
    end
  end

  // A drain coinciding with a fire keeps the register full with the new sum.
  always_comb begin
    state_d   = state_q;
    outData_d = outData_q;
    if (init) begin
      state_d   = OUT_EMPTY;
      outData_d = '0;
    end else if (fire) begin
      state_d   = OUT_FULL;
      outData_d = sumData;
    end else if (state_q == OUT_FULL && out_ready) begin
      state_d   = OUT_EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == OUT_FULL);
    out_data  = outData_q;
  end

`ifdef MLP_RES_SATCNT_EN
  localparam int NW = $clog2(LANES + 1);

  logic [NW-1:0] clampNum;
  logic [16:0]   satSum;
  logic [15:0]   satCount_q, satCount_d;

  always_comb begin
    clampNum = '0;
    for (int i = 0; i < LANES; i++) clampNum = clampNum + NW'(clampMask[i]);
  end

  always_comb begin
    satSum     = {1'b0, satCount_q} + 17'(clampNum);
    satCount_d = satCount_q;
    if (init)      satCount_d = '0;
    else if (fire) satCount_d = satSum[16] ? 16'hFFFF : satSum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) satCount_q <= '0;
    else          satCount_q <= satCount_d;
  end

  assign sat_count = satCount_q;
`else
  logic unusedClamp;
  assign unusedClamp = ^clampMask;
`endif

endmodule

// File: tb/tb_mlp_residual_add.sv
// Directed bench for mlp_residual_add: skip operands and expected sums tracked in
// scoreboard queues, outputs compared at mid-cycle with immediate assertions.
module tb_mlp_residual_add;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init;
  logic        ready;
  logic        skip_valid;
  logic        skip_ready;
  logic [31:0] skip_data;
  logic        mlp_valid;
  logic        mlp_ready;
  logic [31:0] mlp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef MLP_RES_SATCNT_EN
  logic [15:0] sat_count;
`endif

  int          checkCount = 0;
  int          errorCount = 0;
  int          expSat = 0;
  logic [31:0] skipQ[$];
  logic [31:0] expQ[$];

  mlp_residual_add dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init       (init),
    .ready      (ready),
    .skip_valid (skip_valid),
    .skip_ready (skip_ready),
    .skip_data  (skip_data),
    .mlp_valid  (mlp_valid),
    .mlp_ready  (mlp_ready),
    .mlp_data   (mlp_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef MLP_RES_SATCNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelSum(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic int modelClamps(input logic [31:0] a, input logic [31:0] b);
    int s;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
      if (s > 127 || s < -128) n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Records a fire in the scoreboard: pops the matching skip, queues the sum.
  task automatic recordFire(input logic [31:0] mlp);
    logic [31:0] a;
    a = (skipQ.size() > 0) ? skipQ.pop_front() : 32'hxxxxxxxx;
    expQ.push_back(modelSum(a, mlp));
    expSat += modelClamps(a, mlp);
    if (expSat > 65535) expSat = 65535;
  endtask

  // Holds one valid until the DUT handshakes it; starts and ends just after a negedge.
  task automatic applyStimulus(input bit isMlp, input logic [31:0] data, input string tag);
    bit done;
    bit hs;
    done = 1'b0;
    if (isMlp) begin
      mlp_valid = 1'b1;
      mlp_data  = data;
    end else begin
      skip_valid = 1'b1;
      skip_data  = data;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      #1 hs = isMlp ? mlp_ready : skip_ready;
      @(posedge clk);
      if (hs) begin
        done = 1'b1;
        if (isMlp) recordFire(data);
        else       skipQ.push_back(data);
      end
      @(negedge clk);
    end
    if (isMlp) mlp_valid = 1'b0;
    else       skip_valid = 1'b0;
    checkOutput({tag, "_handshake"}, {31'b0, done}, 32'd1);
  endtask

  // Waits for out_valid, compares against the scoreboard head, then drains one beat.
  task automatic collect(input string tag);
    bit seen;
    logic [31:0] e;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checkOutput({tag, "_valid"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxxxxxx;
      checkOutput({tag, "_data"}, out_data, e);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    reset_n    = 1'b0;
    init       = 1'b0;
    skip_valid = 1'b0;
    skip_data  = '0;
    mlp_valid  = 1'b0;
    mlp_data   = '0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_ready", {31'b0, ready}, 32'd1);
    checkOutput("rst_skip_ready", {31'b0, skip_ready}, 32'd1);
    checkOutput("rst_mlp_ready", {31'b0, mlp_ready}, 32'd0);
`ifdef MLP_RES_SATCNT_EN
    checkOutput("rst_sat_count", {16'b0, sat_count}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic add with one-cycle latency
    applyStimulus(1'b0, 32'h01020304, "t2_skip");
    #1 checkOutput("t2_mlp_ready", {31'b0, mlp_ready}, 32'd1);
    applyStimulus(1'b1, 32'h10203040, "t2_mlp");
    #1 checkOutput("t2_latency", {31'b0, out_valid}, 32'd1);
    collect("t2_out");
    #1 checkOutput("t2_ready", {31'b0, ready}, 32'd1);

    // Saturation on two lanes
    applyStimulus(1'b0, 32'h7F800000, "t3_skip");
    applyStimulus(1'b1, 32'h01FF7F81, "t3_mlp");
    collect("t3_out");
`ifdef MLP_RES_SATCNT_EN
    #1 checkOutput("t3_sat_count", {16'b0, sat_count}, expSat);
`endif

    // Fill to full, then a refused push alongside the first pop, then drain in order
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, i, "t4_push");
    #1 checkOutput("t4_full", {31'b0, skip_ready}, 32'd0);
    skip_valid = 1'b1;
    skip_data  = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h0, "t4_fire0");
    skip_valid = 1'b0;
    #1 checkOutput("t4_skip_ready_after_pop", {31'b0, skip_ready}, 32'd1);
    collect("t4_out");
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b1, 32'h0, "t4_fire");
      collect("t4_out");
    end
    #1 checkOutput("t4_drained", {31'b0, ready}, 32'd1);

    // Backpressure, then drain + fire + push in one cycle
    applyStimulus(1'b0, 32'h05050505, "t5_skip_a");
    applyStimulus(1'b0, 32'h7A7A7A7A, "t5_skip_b");
    applyStimulus(1'b1, 32'h01010101, "t5_mlp_a");
    mlp_valid = 1'b1;
    mlp_data  = 32'h10101010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t5_hold_data", out_data, expQ[0]);
      checkOutput("t5_stall", {31'b0, mlp_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready  = 1'b1;
    skip_valid = 1'b1;
    skip_data  = 32'h81818181;
    #1;
    checkOutput("t5_ready_again", {31'b0, mlp_ready}, 32'd1);
    a = expQ.pop_front();
    checkOutput("t5_pre_drain", out_data, a);
    @(posedge clk);
    recordFire(mlp_data);
    skipQ.push_back(skip_data);
    @(negedge clk);
    mlp_valid  = 1'b0;
    skip_valid = 1'b0;
    out_ready  = 1'b0;
    #1 checkOutput("t5_valid_kept", {31'b0, out_valid}, 32'd1);
    collect("t5_out_b");
    applyStimulus(1'b1, 32'h80808080, "t5_mlp_c");
    collect("t5_out_c");
    #1 checkOutput("t5_ready", {31'b0, ready}, 32'd1);
`ifdef MLP_RES_SATCNT_EN
    checkOutput("t5_sat_count", {16'b0, sat_count}, expSat);
`endif

    // init with three entries queued and the output register full
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h00000100 + i, "t6_push");
    applyStimulus(1'b1, 32'h00000001, "t6_mlp");
    #1 checkOutput("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    init       = 1'b1;
    skip_valid = 1'b1;
    skip_data  = 32'hCAFECAFE;
    mlp_valid  = 1'b1;
    mlp_data   = 32'h00000001;
    #1 checkOutput("t6_mlp_ready_init", {31'b0, mlp_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    init       = 1'b0;
    skip_valid = 1'b0;
    mlp_valid  = 1'b0;
    skipQ.delete();
    expQ.delete();
    expSat = 0;
    #1;
    checkOutput("t6_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("t6_out_data", out_data, 32'd0);
    checkOutput("t6_ready", {31'b0, ready}, 32'd1);
    checkOutput("t6_mlp_ready", {31'b0, mlp_ready}, 32'd0);
`ifdef MLP_RES_SATCNT_EN
    checkOutput("t6_sat_count", {16'b0, sat_count}, 32'd0);
`endif
    applyStimulus(1'b0, 32'h02020202, "t6_skip_after");
    applyStimulus(1'b1, 32'h03030303, "t6_mlp_after");
    collect("t6_out_after");

    // Asynchronous reset between edges drops queued data immediately
    applyStimulus(1'b0, 32'h11111111, "t7_skip");
    #3 reset_n = 1'b0;
    #1;
    checkOutput("t7_ready", {31'b0, ready}, 32'd1);
    checkOutput("t7_mlp_ready", {31'b0, mlp_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    skipQ.delete();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
